uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, and a
// one-entry valid/ready output holding register with overrun/frame-error pulses.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 25000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       sense,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t           state, state_nxt;
  logic             sense_p0, sense_p1, sync_s;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             deliver, stop_err;

  // Stage p0/p1: metastability synchronizer, reset to the idle-high level
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sense_p0 <= 1'b1;
      sense_p1 <= 1'b1;
    end else begin
      sense_p0 <= sense;
      sense_p1 <= sense_p0;
    end
  end

  assign sync_s = sense_p1;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    deliver     = 1'b0;
    stop_err    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
        if (!sync_s) state_nxt = START;
      end
      START: begin
        // Re-check the start bit at its midpoint; a high level means a glitch
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = sync_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shreg_nxt   = {sync_s, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (sync_s) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_err  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line recovers so a break is not seen as a start bit
        if (sync_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

  // Output holding register: a delivery coinciding with a consume replaces the byte
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_err;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at CLKS_PER_BIT=8: frame reception, glitch
// rejection, framing error, overrun, same-cycle consume, and mid-frame reset.
module tb_uart_rx_ctrl;
  localparam int CPB = 8;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       sense = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in(clk_in), .rst(rst), .sense(sense), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun)   ov_cnt = ov_cnt + 1;
  end

  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int i);
    if (i < CPB) return 1'b0;
    if (i < 9 * CPB) return d[(i / CPB) - 1];
    return stop;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // ready_at >= 0 drives rx_ready high only in that frame cycle
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len,
                            input int ready_at);
    for (int i = 0; i < 9 * CPB + stop_len; i++) begin
      tick();
      sense = frame_bit(d, stop, i);
      if (ready_at >= 0) rx_ready = (i == ready_at);
    end
    tick();
    sense = 1'b1;
  endtask

  task automatic consume(input logic [7:0] exp_data);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL consume_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== exp_data) begin errors++; $display("FAIL consume_data got=%h exp=%h", rx_data, exp_data); end
  endtask

  task automatic test_reset();
    rst = 1'b1; sense = 1'b1; rx_ready = 1'b0;
    repeat (3) tick();
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", frame_err, overrun); end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_basic_frame();
    send_frame(8'h49, 1'b1, CPB, -1);
    checks++; if (rx_data !== 8'h49) begin errors++; $display("FAIL basic_data got=%h exp=49", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", rx_busy); end
    checks++; if (fe_cnt !== 0 || ov_cnt !== 0) begin errors++; $display("FAIL basic_flags got fe=%0d ov=%0d exp 0 0", fe_cnt, ov_cnt); end
    consume(8'h49);
    rx_ready = 1'b1;
    repeat (2) tick();
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h49) begin errors++; $display("FAIL idle_ready got=%b/%h exp=0/49", rx_valid, rx_data); end
  endtask

  task automatic test_glitch();
    int busy_cycles = 0;
    int fe0 = fe_cnt;
    sense = 1'b0;
    repeat (2) tick();
    sense = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rx_busy === 1'b1) busy_cycles++;
      tick();
    end
    checks++; if (busy_cycles < 1 || busy_cycles > 6) begin errors++; $display("FAIL glitch_busy_len got=%0d exp=1..6", busy_cycles); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got=%b exp=0", rx_busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got=%b exp=0", rx_valid); end
    checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL glitch_fe got=%0d exp=%0d", fe_cnt - fe0, 0); end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_cnt;
    for (int i = 0; i < 9 * CPB + 40; i++) begin
      tick();
      sense = frame_bit(8'h55, 1'b0, i);
    end
    tick();
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL break_busy got=%b exp=1", rx_busy); end
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL frame_err_pulses got=%0d exp=1", fe_cnt - fe0); end
    sense = 1'b1;
    repeat (6) tick();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_release got=%b exp=0", rx_busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_err_valid got=%b exp=0", rx_valid); end
  endtask

  task automatic test_overrun();
    int ov0 = ov_cnt;
    send_frame(8'h49, 1'b1, CPB, -1);
    checks++; if (ov_cnt !== ov0) begin errors++; $display("FAIL overrun_early got=%0d exp=0", ov_cnt - ov0); end
    send_frame(8'hA3, 1'b1, CPB, -1);
    checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL overrun_pulses got=%0d exp=1", ov_cnt - ov0); end
    checks++; if (rx_data !== 8'h49 || rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_hold got=%h/%b exp=49/1", rx_data, rx_valid); end
    consume(8'h49);
  endtask

  task automatic test_back_to_back();
    int ov0 = ov_cnt;
    send_frame(8'h49, 1'b1, CPB, -1);
    send_frame(8'hA3, 1'b1, CPB, 10 * CPB - 2);
    rx_ready = 1'b0;
    checks++; if (rx_data !== 8'hA3) begin errors++; $display("FAIL b2b_data got=%h exp=A3", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", rx_valid); end
    checks++; if (ov_cnt !== ov0) begin errors++; $display("FAIL b2b_overrun got=%0d exp=0", ov_cnt - ov0); end
  endtask

  task automatic test_reset_mid_frame();
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    for (int i = 0; i < 5 * CPB + 4; i++) begin
      tick();
      sense = frame_bit(8'h49, 1'b1, i);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sense = 1'b1;
    checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_out got=%h/%b exp=00/0", rx_data, rx_valid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", rx_busy); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midrst_flags got=%b%b exp=00", frame_err, overrun); end
    repeat (20) tick();
    checks++; if (fe_cnt !== fe0 || ov_cnt !== ov0 || rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet got fe=%0d ov=%0d busy=%b exp 0 0 0", fe_cnt - fe0, ov_cnt - ov0, rx_busy); end
    send_frame(8'h49, 1'b1, CPB, -1);
    checks++; if (rx_data !== 8'h49 || rx_valid !== 1'b1) begin errors++; $display("FAIL postrst_frame got=%h/%b exp=49/1", rx_data, rx_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
